// File: rtl/ret_addr_stack_pkg.sv
// Shared return-stack constants and types for the fetch-stage predictor.
// The RAS depth and pointer width are defined once here so that the stack
// and the branch checkpoint logic always agree on their sizes.
package ret_addr_stack_pkg;

  localparam int RET_STACK_SIZE        = 16;
  localparam int RET_PRED_POINTER_SIZE = 4;

  // A return address, as pushed by a call (call PC + 4)
  typedef logic [31:0] ret_addr_t;

  // State saved with each predicted branch, so a misprediction can rewind the stack
  typedef struct packed {
    logic [RET_PRED_POINTER_SIZE-1:0] ptr;
    logic [RET_PRED_POINTER_SIZE:0]   cnt;
  } ras_ckpt_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Return address stack (circular LIFO) for the fetch-stage branch predictor.
// Calls push their return address and returns pop the predicted target.
// When the stack is full, a push overwrites the oldest entry. When it is
// empty, a pop reports a miss (pop_hit_o = 0) and pop_addr_o reads 0.
// Optional macro RAS_OVF_CNT_EN adds two saturating 16-bit counters:
// ovf_cnt_o counts pushes while full, and unf_cnt_o counts pops while empty.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int DEPTH  = RET_STACK_SIZE,
  parameter int PTR_W  = RET_PRED_POINTER_SIZE,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              pop_valid_i,
  output logic [ADDR_W-1:0] pop_addr_o,
  output logic              pop_hit_o,
  output logic [PTR_W-1:0]  tos_ptr_o,
  output logic [PTR_W:0]    count_o,
  input  logic              restore_i,
  input  logic [PTR_W-1:0]  restore_ptr_i,
  input  logic [PTR_W:0]    restore_cnt_i,
  output logic              full_o,
  output logic              empty_o
`ifdef RAS_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_cnt_o,
  output logic [15:0]       unf_cnt_o
`endif
);

  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [PTR_W-1:0]  tos_q;
  logic [PTR_W:0]    cnt_q;
  logic [PTR_W-1:0]  tos_inc;
  logic [PTR_W-1:0]  tos_dec;
  logic              is_empty;
  logic              is_full;

  assign tos_inc  = tos_q + PTR_W'(1);
  assign tos_dec  = tos_q - PTR_W'(1);
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == (PTR_W+1)'(DEPTH));

  assign pop_addr_o = is_empty ? '0 : stack_q[tos_q];
  assign pop_hit_o  = !is_empty;
  assign tos_ptr_o  = tos_q;
  assign count_o    = cnt_q;
  assign full_o     = is_full;
  assign empty_o    = is_empty;

  // Stack update. Priority is reset, then restore, then push/pop. A push+pop
  // pair swaps the top entry in place. On an empty stack it acts as a push.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      tos_q <= PTR_W'(DEPTH - 1);
      cnt_q <= '0;
    end else if (restore_i) begin
      tos_q <= restore_ptr_i;
      cnt_q <= restore_cnt_i;
    end else if (push_valid_i && (!pop_valid_i || is_empty)) begin
      tos_q          <= tos_inc;
      stack_q[tos_inc] <= push_addr_i;
      if (!is_full) cnt_q <= cnt_q + (PTR_W+1)'(1);
    end else if (push_valid_i && pop_valid_i) begin
      stack_q[tos_q] <= push_addr_i;
    end else if (pop_valid_i && !is_empty) begin
      tos_q <= tos_dec;
      cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end

`ifdef RAS_OVF_CNT_EN
  logic [15:0] ovf_q;
  logic [15:0] unf_q;

  assign ovf_cnt_o = ovf_q;
  assign unf_cnt_o = unf_q;

  // Saturating counters for lost entries (push-only while full) and missed
  // predictions (pop-only while empty). Restore cycles are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
      unf_q <= '0;
    end else if (!restore_i) begin
      if (push_valid_i && !pop_valid_i && is_full && ovf_q != 16'hFFFF)
        ovf_q <= ovf_q + 16'd1;
      if (pop_valid_i && !push_valid_i && is_empty && unf_q != 16'hFFFF)
        unf_q <= unf_q + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Return address stack (RAS) for the fetch-stage branch predictor. Call-type instructions push their return address; return-type instructions pop the predicted target.
- Sized by the shared return-stack constants: 16 entries, 4-bit pointer.
- Sits beside the main predictor table, between the decode-side push/pop producers and the fetch-side target mux.
- Circular LIFO: overflow overwrites the oldest entry; underflow reports a miss instead of returning garbage.

Parameters:
- DEPTH, 16, number of entries; equals RET_STACK_SIZE; must be a power of two.
- PTR_W, 4, pointer width; equals RET_PRED_POINTER_SIZE; log2(DEPTH).
- ADDR_W, 32, return address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- push_valid_i  in  1  call detected; push push_addr_i this cycle.
- push_addr_i  in  ADDR_W  return address (call PC + 4).
- pop_valid_i  in  1  return detected; consume top entry this cycle.
- pop_addr_o  out  ADDR_W  current top-of-stack address (peek, combinational from registers).
- pop_hit_o  out  1  1 when the stack holds at least one valid entry, i.e. pop_addr_o is meaningful.
- tos_ptr_o  out  PTR_W  current top pointer, for checkpointing with the branch.
- count_o  out  PTR_W+1  number of valid entries, 0..DEPTH.
- restore_i  in  1  misprediction recovery strobe.
- restore_ptr_i  in  PTR_W  checkpointed top pointer.
- restore_cnt_i  in  PTR_W+1  checkpointed count.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage: DEPTH x ADDR_W register array plus tos_ptr (points at the last written entry) and count.
- Reset (synchronous, active-high): tos_ptr = DEPTH-1, count = 0, array cleared to 0.
  - Resulting outputs: pop_addr_o = 0, pop_hit_o = 0, empty_o = 1, full_o = 0, count_o = 0, tos_ptr_o = DEPTH-1.
  - Reset wins over every other input in the same cycle.
- Read latency: 0. pop_addr_o = array[tos_ptr] whenever count > 0, else 0. pop_hit_o = (count != 0).
- Push only: tos_ptr <= tos_ptr + 1 (mod DEPTH); array[tos_ptr+1] <= push_addr_i; count <= min(count+1, DEPTH).
  - On a push while full, the oldest entry is silently overwritten and count stays at DEPTH.
- Pop only: pop_addr_o is the value sampled this cycle.
  - If count > 0: tos_ptr <= tos_ptr - 1 (mod DEPTH), count <= count - 1.
  - If count == 0 (underflow): no state change and pop_hit_o = 0.
- Push and pop in the same cycle: pop_addr_o returns the old top, then array[tos_ptr] <= push_addr_i. tos_ptr and count are unchanged.
  - If count == 0: treated as a push, so count becomes 1.
- restore_i: highest priority after reset. tos_ptr <= restore_ptr_i, count <= restore_cnt_i; the array is untouched; push/pop in the same cycle are ignored.
- Pointer arithmetic wraps naturally at PTR_W bits. No state machine beyond the pointer/count registers.

Optional Feature:
- Macro RAS_OVF_CNT_EN.
- When defined: adds 16-bit saturating counters with outputs ovf_cnt_o (pushes while full) and unf_cnt_o (pops while empty). Both are cleared by reset and hold at 16'hFFFF.
- When undefined: neither the ports nor the counters exist.

Decomposition:
- Shared package: RET_STACK_SIZE, RET_PRED_POINTER_SIZE, a typedef for a RAS checkpoint struct {ptr, cnt}, and a typedef for the return address (logic [31:0]).
- Single module. The optional counter pair is small enough to stay inline; no sub-module.

Test Plan:
- Reset then idle -> empty_o=1, pop_hit_o=0, pop_addr_o=0, count_o=0.
- Push 0x100, 0x200, 0x300, then three pops -> pop_addr_o reads 0x300, 0x200, 0x100 in order; then empty_o=1.
- 17 pushes 0x1000+4*i (i=0..16), then 16 pops -> count_o stays 16 after push 16; pops return 0x1040 down to 0x1004; 0x1000 is lost; a 17th pop gives pop_hit_o=0 (unf_cnt_o=1 with RAS_OVF_CNT_EN).
- Stack holds 0xA0, 0xB0; simultaneous push 0xC0 + pop -> pop_addr_o=0xB0 that cycle, then top=0xC0, count_o=2.
- Snapshot tos_ptr/count at count=2, push 0xD0, 0xE0, pop once, then assert restore_i with the snapshot -> count_o=2; top returns the pre-snapshot value, unless a later push overwrote that slot (directed case: it did not).
- Assert reset mid-sequence with push_valid_i=1 -> next cycle count_o=0, empty_o=1; the push is dropped.
